battle_round_ctrl: RTL and testbench
====================================

BATTLE_ROUND_CTRL -- requirements
Module: battle_round_ctrl

Interface
REQ-001 Parameter HP_INIT, default 1000, meaning the starting base hit points of both player and enemy.
REQ-002 Parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles allowed for calcDone.
REQ-003 clk  input  1  clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 roundTick  input  1  request to start one battle round.
REQ-006 calcDone  input  1  Done from the damage calculator.
REQ-007 totalUnitDamage  input  12  damage dealt to the enemy base; valid while calcDone=1.
REQ-008 totalEnemyDamage  input  12  damage dealt to the player base; valid while calcDone=1.
REQ-009 calcStart  output  1  Start pulse to the damage calculator.
REQ-010 calcAck  output  1  Ack pulse to the damage calculator.
REQ-011 playerHp  output  12  current player base hit points.
REQ-012 enemyHp  output  12  current enemy base hit points.
REQ-013 roundCount  output  8  number of completed rounds.
REQ-014 busy  output  1  high in every state except IDLE and OVER.
REQ-015 gameOver  output  1  high in the OVER state.
REQ-016 winner  output  2  game result: 00 none, 01 player, 10 enemy, 11 draw.
REQ-017 timeoutErr  output  1  sticky flag: a calculation timed out.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, START, WAIT, ACK, APPLY, OVER.
REQ-019 IDLE: when roundTick=1 is sampled, the FSM SHALL move to START; otherwise it stays in IDLE.
REQ-020 START: calcStart SHALL be 1 for exactly one cycle, and the FSM SHALL then move to WAIT.
REQ-021 WAIT: on the first edge with calcDone=1, the FSM SHALL latch both damage inputs into internal registers and move to ACK.
REQ-022 ACK: calcAck SHALL be 1 for exactly one cycle, and the FSM SHALL then move to APPLY.
REQ-023 calcStart and calcAck SHALL never be 1 in the same cycle.
REQ-024 APPLY: enemyHp SHALL become max(enemyHp - latched unit damage, 0); playerHp SHALL become max(playerHp - latched enemy damage, 0).
REQ-025 All HP subtraction SHALL be saturating and 12-bit; HP SHALL never wrap.
REQ-026 APPLY: roundCount SHALL increment by 1, saturating at 255.
REQ-027 After APPLY, the FSM SHALL move to OVER if either post-update HP is 0; otherwise it returns to IDLE.
REQ-028 winner SHALL be set on entry to OVER, using the post-update HPs: enemy 0 and player >0 gives 01; player 0 and enemy >0 gives 10; both 0 gives 11.
REQ-029 OVER is terminal: roundTick SHALL be ignored, and only rst leaves OVER.
REQ-030 roundTick in any state other than IDLE SHALL be ignored and not queued.
REQ-031 WAIT timeout: a cycle counter SHALL be cleared on entry to WAIT.
REQ-032 If TIMEOUT cycles elapse without calcDone, timeoutErr SHALL be set, the FSM SHALL move to IDLE, and HP and roundCount SHALL be unchanged.
REQ-033 If calcDone=1 in the same cycle the timeout expires, calcDone SHALL take priority.
REQ-034 calcDone outside WAIT SHALL be ignored.
REQ-035 Latency: roundTick sampled at edge N gives calcStart=1 in cycle N+1; calcDone sampled at edge M gives calcAck=1 in cycle M+1 and updated HP visible after edge M+2.

Reset
REQ-036 On rst, the FSM SHALL go to IDLE; playerHp and enemyHp SHALL be HP_INIT; roundCount, winner and the damage latches SHALL be 0; calcStart, calcAck, busy, gameOver and timeoutErr SHALL be 0.
REQ-037 rst asserted mid-round (any state) SHALL abort the round with no HP update, and the reset values SHALL be visible after that edge.

Structure
REQ-038 The shared package SHALL hold the state encoding, the DMG_W=12, HP_W=12 and RC_W=8 width constants, and the winner code constants.
REQ-039 One sub-module, hp_sat_sub (12-bit saturating subtractor with a zero flag), SHALL be instantiated twice: once per base.

Verification
REQ-040 Nominal round: tick, then calcDone with unit=150, enemy=140 → one calcStart pulse, one calcAck pulse, enemyHp=850, playerHp=860, roundCount=1, busy=0.
REQ-041 Zero-damage round: unit=0, enemy=0 → HP stays 1000/1000, roundCount=1, gameOver=0.
REQ-042 Saturation: unit=1200, enemy=10 → enemyHp=0, playerHp=990, gameOver=1, winner=01; a later roundTick produces no calcStart.
REQ-043 Draw: with HP preset to 100/100 over earlier rounds, unit=100, enemy=300 → both HP 0, winner=11.
REQ-044 Timeout: tick with calcDone held low → timeoutErr=1 after 255 WAIT cycles, FSM back in IDLE, HP and roundCount unchanged; the next round completes normally.
REQ-045 Reset in WAIT: rst applied 3 cycles after calcStart → all outputs at reset values; a late calcDone is ignored.

Source files
------------

// File: rtl/battle_round_ctrl_pkg.sv
// battle_round_ctrl_pkg: shared widths, FSM state encoding and winner codes for the battle round controller
package battle_round_ctrl_pkg;
    localparam int DMG_W = 12;
    localparam int HP_W = 12;
    localparam int RC_W = 8;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ACK = 3'd3;
    localparam logic [2:0] S_APPLY = 3'd4;
    localparam logic [2:0] S_OVER = 3'd5;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_PLAYER = 2'b01;
    localparam logic [1:0] WIN_ENEMY = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;
    function automatic logic [RC_W-1:0] satInc(input logic [RC_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/hp_sat_sub.sv
// hp_sat_sub: saturating hit-point subtractor that clamps at zero and flags a zero result
module hp_sat_sub
    import battle_round_ctrl_pkg::*;
(
    input  logic [HP_W-1:0]  hp,
    input  logic [DMG_W-1:0] dmg,
    output logic [HP_W-1:0]  diff,
    output logic             zero
);
    // clamp at zero instead of wrapping when damage exceeds remaining hp
    always_comb begin
        diff = (hp > dmg) ? hp - dmg : '0;
        zero = (diff == '0);
    end
endmodule

// File: rtl/battle_round_ctrl.sv
// battle_round_ctrl: sequences one battle round per tick through the damage calculator and tracks base hp
module battle_round_ctrl
    import battle_round_ctrl_pkg::*;
#(
    parameter int HP_INIT = 1000,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             roundTick,
    input  logic             calcDone,
    input  logic [DMG_W-1:0] totalUnitDamage,
    input  logic [DMG_W-1:0] totalEnemyDamage,
    output logic             calcStart,
    output logic             calcAck,
    output logic [HP_W-1:0]  playerHp,
    output logic [HP_W-1:0]  enemyHp,
    output logic [RC_W-1:0]  roundCount,
    output logic             busy,
    output logic             gameOver,
    output logic [1:0]       winner,
    output logic             timeoutErr
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [HP_W-1:0] HP_RST = HP_W'(HP_INIT);

    logic [2:0]       state;
    logic [2:0]       nextState;
    logic [CNT_W-1:0] waitCnt;
    logic             waitExpired;
    logic [DMG_W-1:0] unitDmg;
    logic [DMG_W-1:0] enemyDmg;
    logic [HP_W-1:0]  enemyNext;
    logic [HP_W-1:0]  playerNext;
    logic             enemyZero;
    logic             playerZero;

    hp_sat_sub uEnemySub (
        .hp   (enemyHp),
        .dmg  (unitDmg),
        .diff (enemyNext),
        .zero (enemyZero)
    );

    hp_sat_sub uPlayerSub (
        .hp   (playerHp),
        .dmg  (enemyDmg),
        .diff (playerNext),
        .zero (playerZero)
    );

    assign calcStart = (state == S_START);
    assign calcAck = (state == S_ACK);
    assign busy = (state != S_IDLE) && (state != S_OVER);
    assign gameOver = (state == S_OVER);
    assign waitExpired = (waitCnt == CNT_LAST);

    // round sequencing; calcDone beats an expiring timeout in the same cycle
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  nextState = roundTick ? S_START : S_IDLE;
            S_START: nextState = S_WAIT;
            S_WAIT:  nextState = calcDone ? S_ACK : (waitExpired ? S_IDLE : S_WAIT);
            S_ACK:   nextState = S_APPLY;
            S_APPLY: nextState = (enemyZero || playerZero) ? S_OVER : S_IDLE;
            S_OVER:  nextState = S_OVER;
            default: nextState = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= nextState;
    end

    // wait counter is held at zero outside WAIT, so every WAIT entry starts from zero
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) waitCnt <= '0;
        else waitCnt <= waitCnt + 1'b1;
    end

    // capture both damage values on the cycle the calculator reports done
    always_ff @(posedge clk) begin
        if (rst) begin
            unitDmg <= '0;
            enemyDmg <= '0;
        end else if (state == S_WAIT && calcDone) begin
            unitDmg <= totalUnitDamage;
            enemyDmg <= totalEnemyDamage;
        end
    end

    // apply latched damage, count the round and decide the winner from post-update hp
    always_ff @(posedge clk) begin
        if (rst) begin
            playerHp <= HP_RST;
            enemyHp <= HP_RST;
            roundCount <= '0;
            winner <= WIN_NONE;
        end else if (state == S_APPLY) begin
            playerHp <= playerNext;
            enemyHp <= enemyNext;
            roundCount <= satInc(roundCount);
            winner <= playerZero ? (enemyZero ? WIN_DRAW : WIN_ENEMY)
                                 : (enemyZero ? WIN_PLAYER : WIN_NONE);
        end
    end

    // sticky record that the calculator failed to answer in time
    always_ff @(posedge clk) begin
        if (rst) timeoutErr <= 1'b0;
        else if (state == S_WAIT && !calcDone && waitExpired) timeoutErr <= 1'b1;
    end
endmodule

// File: tb/tb_battle_round_ctrl.sv
// tb_battle_round_ctrl: directed and randomized rounds checked against an arithmetic model of the game rules
module tb_battle_round_ctrl;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        roundTick = 1'b0;
    logic        calcDone = 1'b0;
    logic [11:0] totalUnitDamage = '0;
    logic [11:0] totalEnemyDamage = '0;
    logic        calcStart;
    logic        calcAck;
    logic [11:0] playerHp;
    logic [11:0] enemyHp;
    logic [7:0]  roundCount;
    logic        busy;
    logic        gameOver;
    logic [1:0]  winner;
    logic        timeoutErr;

    int nCmp = 0;
    int nErr = 0;
    int startCnt = 0;
    int ackCnt = 0;
    int mP, mE, mRc, mWin;
    bit mOver, mTo;

    battle_round_ctrl #(.HP_INIT(1000), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .roundTick        (roundTick),
        .calcDone         (calcDone),
        .totalUnitDamage  (totalUnitDamage),
        .totalEnemyDamage (totalEnemyDamage),
        .calcStart        (calcStart),
        .calcAck          (calcAck),
        .playerHp         (playerHp),
        .enemyHp          (enemyHp),
        .roundCount       (roundCount),
        .busy             (busy),
        .gameOver         (gameOver),
        .winner           (winner),
        .timeoutErr       (timeoutErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (calcStart) startCnt++;
        if (calcAck) ackCnt++;
        if (calcStart || calcAck) chk("startAckExclusive", {31'b0, calcStart & calcAck}, 0);
    end

    task automatic modelReset();
        mP = 1000; mE = 1000; mRc = 0; mWin = 0; mOver = 0; mTo = 0;
    endtask

    task automatic checkAll(input string ph);
        chk({ph, ":playerHp"}, {20'b0, playerHp}, mP);
        chk({ph, ":enemyHp"}, {20'b0, enemyHp}, mE);
        chk({ph, ":roundCount"}, {24'b0, roundCount}, mRc);
        chk({ph, ":winner"}, {30'b0, winner}, mWin);
        chk({ph, ":gameOver"}, {31'b0, gameOver}, {31'b0, mOver});
        chk({ph, ":busy"}, {31'b0, busy}, 0);
        chk({ph, ":timeoutErr"}, {31'b0, timeoutErr}, {31'b0, mTo});
    endtask

    task automatic doReset();
        rst = 1'b1; roundTick = 1'b0; calcDone = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkAll("reset");
        chk("reset:calcStart", {31'b0, calcStart}, 0);
        chk("reset:calcAck", {31'b0, calcAck}, 0);
    endtask

    task automatic doRound(input string ph, input int u, input int e, input int d, input bit noise);
        startCnt = 0; ackCnt = 0;
        roundTick = 1'b1;
        @(negedge clk);
        roundTick = 1'b0;
        chk({ph, ":calcStart"}, {31'b0, calcStart}, 1);
        chk({ph, ":busyStart"}, {31'b0, busy}, 1);
        @(negedge clk);
        for (int i = 0; i < d; i++) begin
            totalUnitDamage = 12'($urandom);
            totalEnemyDamage = 12'($urandom);
            roundTick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        roundTick = 1'b0;
        totalUnitDamage = 12'(u);
        totalEnemyDamage = 12'(e);
        calcDone = 1'b1;
        @(negedge clk);
        calcDone = 1'b0;
        totalUnitDamage = 12'($urandom);
        totalEnemyDamage = 12'($urandom);
        roundTick = noise;
        chk({ph, ":calcAck"}, {31'b0, calcAck}, 1);
        @(negedge clk);
        roundTick = 1'b0;
        @(negedge clk);
        mE = (mE > u) ? mE - u : 0;
        mP = (mP > e) ? mP - e : 0;
        mRc = (mRc < 255) ? mRc + 1 : 255;
        if (mE == 0 || mP == 0) begin
            mOver = 1;
            mWin = (mE == 0 && mP == 0) ? 3 : (mE == 0) ? 1 : 2;
        end
        checkAll(ph);
        chk({ph, ":startPulses"}, startCnt, 1);
        chk({ph, ":ackPulses"}, ackCnt, 1);
        @(negedge clk);
        chk({ph, ":noQueuedTick"}, {30'b0, busy, calcStart}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        modelReset();
        @(negedge clk);
        @(negedge clk);
        doReset();

        doRound("nominal", 150, 140, 2, 0);
        chk("nominal:enemy850", {20'b0, enemyHp}, 850);
        chk("nominal:player860", {20'b0, playerHp}, 860);

        doReset();
        doRound("zeroDmg", 0, 0, 0, 0);

        doReset();
        doRound("saturate", 1200, 10, 1, 0);
        chk("saturate:winner01", {30'b0, winner}, 1);
        startCnt = 0;
        roundTick = 1'b1;
        repeat (4) @(negedge clk);
        roundTick = 1'b0;
        @(negedge clk);
        chk("over:noStart", startCnt, 0);
        checkAll("overHold");

        doReset();
        doRound("drawPre", 900, 900, 0, 0);
        doRound("draw", 100, 300, 4, 0);

        doReset();
        doRound("enemyWin", 5, 4000, 0, 0);

        doReset();
        startCnt = 0; ackCnt = 0;
        roundTick = 1'b1;
        @(negedge clk);
        roundTick = 1'b0;
        chk("timeout:calcStart", {31'b0, calcStart}, 1);
        repeat (TMO) @(negedge clk);
        chk("timeout:busyLast", {31'b0, busy}, 1);
        chk("timeout:errLate", {31'b0, timeoutErr}, 0);
        @(negedge clk);
        mTo = 1;
        checkAll("timeout");
        chk("timeout:noAck", ackCnt, 0);
        doRound("afterTimeout", 20, 30, 3, 0);
        doRound("donePriority", 10, 10, TMO - 1, 0);

        doReset();
        doRound("preRst", 100, 50, 0, 0);
        ackCnt = 0;
        roundTick = 1'b1;
        @(negedge clk);
        roundTick = 1'b0;
        chk("rstWait:calcStart", {31'b0, calcStart}, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkAll("rstWait");
        chk("rstWait:calcStart0", {31'b0, calcStart}, 0);
        calcDone = 1'b1;
        totalUnitDamage = 12'd500;
        totalEnemyDamage = 12'd500;
        repeat (3) @(negedge clk);
        calcDone = 1'b0;
        checkAll("lateDone");
        chk("lateDone:noAck", ackCnt, 0);

        doReset();
        repeat (257) doRound("rcSat", 0, 0, 0, 0);
        chk("rcSat:255", {24'b0, roundCount}, 255);

        doReset();
        for (int n = 0; n < 200 && !mOver; n++)
            doRound("random", $urandom_range(0, 400), $urandom_range(0, 400), $urandom_range(0, 12), 1);
        chk("random:over", {31'b0, gameOver}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
